// File: rtl/lagd_pkg.sv
// Shared constants and types for the coupling-weight row loader.
// Default geometry, beat/row arithmetic helpers and the fill FSM state type.
package lagd_pkg;

    localparam int N_DEF        = 256;
    localparam int DATAW_DEF    = 4;
    localparam int BUSW_DEF     = 64;
    localparam int NUM_ROWS_DEF = 256;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fill_state_e;

    function automatic int calc_epb(input int busw, input int dataw);
        return busw / dataw;
    endfunction

    function automatic int calc_bpr(input int n, input int dataw, input int busw);
        return (n * dataw) / busw;
    endfunction

endpackage

// File: rtl/weight_clamp.sv
// Per-beat clamp of the most-negative 2's-complement code to its symmetric neighbour.
// Also reports how many elements of the beat were clamped.
module weight_clamp #(
    parameter int DATAW = 4,
    parameter int EPB   = 16,
    parameter int CNTW  = $clog2(EPB + 1)
) (
    input  logic [EPB*DATAW-1:0] beat_i,
    output logic [EPB*DATAW-1:0] beat_o,
    output logic [CNTW-1:0]      hit_cnt_o
);

    localparam logic [DATAW-1:0] MOST_NEG = {1'b1, {(DATAW-1){1'b0}}};
    localparam logic [DATAW-1:0] MIN_SYM  = MOST_NEG + DATAW'(1);

    always_comb begin
        beat_o    = beat_i;
        hit_cnt_o = '0;
        for (int j = 0; j < EPB; j++) begin
            if (beat_i[j*DATAW +: DATAW] == MOST_NEG) begin
                beat_o[j*DATAW +: DATAW] = MIN_SYM;
                hit_cnt_o                = hit_cnt_o + CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/weight_row_loader.sv
// Deserialises a narrow beat stream of 2C weights into double-buffered full rows.
// Optional most-negative clamp and clamp counter under LAGD_WLOAD_CLAMP_EN.
//
// state | meaning
// FILL  | accepting beats into the fill buffer
// HOLD  | fill buffer complete, waiting for the output slot to drain
module weight_row_loader
    import lagd_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int DATAW    = DATAW_DEF,
    parameter int BUSW     = BUSW_DEF,
    parameter int NUM_ROWS = NUM_ROWS_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [BUSW-1:0]               in_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [N-1:0][DATAW-1:0]       row_2c_o,
    output logic [$clog2(NUM_ROWS)-1:0]   row_idx_o,
    output logic                          last_row_o
`ifdef LAGD_WLOAD_CLAMP_EN
   ,output logic [15:0]                   clamp_cnt_o
`endif
);

    localparam int EPB  = calc_epb(BUSW, DATAW);
    localparam int BPR  = calc_bpr(N, DATAW, BUSW);
    localparam int ROWW = N * DATAW;
    localparam int BCW  = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int IDXW = $clog2(NUM_ROWS);

    if ((N * DATAW) % BUSW != 0) begin : g_bad_geometry
        $error("weight_row_loader: N*DATAW must be a multiple of BUSW");
    end

    fill_state_e     r_state, w_state_nxt;
    logic [BCW-1:0]  r_beat_cnt;
    logic [ROWW-1:0] r_fill, w_fill_nxt, r_out;
    logic            r_out_valid;
    logic [IDXW-1:0] r_row_idx;
    logic [BUSW-1:0] w_beat;
    logic            w_accept, w_last_beat, w_out_hs, w_transfer;

    assign in_ready_o  = (r_state == FILL);
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_last_beat = w_accept && (r_beat_cnt == BCW'(BPR - 1));
    assign w_out_hs    = r_out_valid && out_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_transfer  = 1'b0;
        case (r_state)
            FILL: begin
                if (w_last_beat) begin
                    if (!r_out_valid || out_ready_i) w_transfer  = 1'b1;
                    else                             w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_out_hs) begin
                    w_transfer  = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Merge the incoming beat so the last beat can go straight to the output slot.
    always_comb begin
        w_fill_nxt = r_fill;
        if (w_accept) w_fill_nxt[int'(r_beat_cnt)*BUSW +: BUSW] = w_beat;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      r_state <= FILL;
        else if (flush_i) r_state <= FILL;
        else              r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_beat_cnt  <= '0;
            r_fill      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_row_idx   <= '0;
        end else if (flush_i) begin
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_row_idx   <= '0;
        end else begin
            if (w_accept) begin
                r_fill     <= w_fill_nxt;
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + BCW'(1);
            end
            if (w_transfer) begin
                r_out       <= w_fill_nxt;
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_hs) begin
                r_row_idx <= (r_row_idx == IDXW'(NUM_ROWS - 1)) ? '0 : r_row_idx + IDXW'(1);
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign row_2c_o    = r_out;
    assign row_idx_o   = r_row_idx;
    assign last_row_o  = (r_row_idx == IDXW'(NUM_ROWS - 1));

`ifdef LAGD_WLOAD_CLAMP_EN
    localparam int HCW = $clog2(EPB + 1);

    logic [HCW-1:0] w_hits;
    logic [16:0]    w_cnt_sum;
    logic [15:0]    r_clamp_cnt;

    weight_clamp #(
        .DATAW (DATAW),
        .EPB   (EPB),
        .CNTW  (HCW)
    ) u_clamp (
        .beat_i    (in_data_i),
        .beat_o    (w_beat),
        .hit_cnt_o (w_hits)
    );

    assign w_cnt_sum = {1'b0, r_clamp_cnt} + 17'(w_hits);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_clamp_cnt <= '0;
        else if (flush_i)  r_clamp_cnt <= '0;
        else if (w_accept) r_clamp_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end

    assign clamp_cnt_o = r_clamp_cnt;
`else
    assign w_beat = in_data_i;
`endif

endmodule

// File: tb/tb_weight_row_loader.sv
// Self-checking bench for weight_row_loader: directed table, hand sequences and
// random traffic checked against a row-queue reference model.
module tb_weight_row_loader;

    localparam int N        = 256;
    localparam int DATAW    = 4;
    localparam int BUSW     = 64;
    localparam int NUM_ROWS = 4;
    localparam int EPB      = BUSW / DATAW;
    localparam int BPR      = N * DATAW / BUSW;
    localparam int ROWW     = N * DATAW;
`ifdef LAGD_WLOAD_CLAMP_EN
    localparam logic [3:0] NEG_OUT = 4'h9;
`else
    localparam logic [3:0] NEG_OUT = 4'h8;
`endif

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0;
    logic in_valid_i = 1'b0;
    logic out_ready_i = 1'b0;
    logic [BUSW-1:0] in_data_i = '0;
    logic in_ready_o, out_valid_o, last_row_o;
    logic [N-1:0][DATAW-1:0] row_2c_o;
    logic [1:0] row_idx_o;
`ifdef LAGD_WLOAD_CLAMP_EN
    logic [15:0] clamp_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    weight_row_loader #(.N(N), .DATAW(DATAW), .BUSW(BUSW), .NUM_ROWS(NUM_ROWS)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .row_2c_o    (row_2c_o),
        .row_idx_o   (row_idx_o),
        .last_row_o  (last_row_o)
`ifdef LAGD_WLOAD_CLAMP_EN
       ,.clamp_cnt_o (clamp_cnt_o)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: completed rows awaiting consumption, the partial row, handshakes since flush.
    logic [ROWW-1:0] rowq[$];
    logic [ROWW-1:0] partial;
    int pbeats = 0;
    int hs_cnt = 0;
    int m_clamp = 0;
    int hs_log[$];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         probe;
        logic [3:0] exp_val;
        logic [1:0] exp_idx;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_row(input string name, input logic [ROWW-1:0] act, input logic [ROWW-1:0] exp);
        int first;
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            first = 0;
            for (int i = N - 1; i >= 0; i--) if (act[i*4 +: 4] !== exp[i*4 +: 4]) first = i;
            $display("FAIL %s: element %0d got %h expected %h at %0t",
                     name, first, act[first*4 +: 4], exp[first*4 +: 4], $time);
        end
    endtask

    function automatic logic [BUSW-1:0] ref_clamp(input logic [BUSW-1:0] b);
`ifdef LAGD_WLOAD_CLAMP_EN
        for (int j = 0; j < EPB; j++) if (b[j*4 +: 4] == 4'b1000) b[j*4 +: 4] = 4'b1001;
`endif
        return b;
    endfunction

    function automatic int count_neg(input logic [BUSW-1:0] b);
        int c = 0;
        for (int j = 0; j < EPB; j++) if (b[j*4 +: 4] == 4'b1000) c++;
        return c;
    endfunction

    function automatic logic [ROWW-1:0] clamp_row(input logic [ROWW-1:0] r);
        for (int k = 0; k < BPR; k++) r[k*BUSW +: BUSW] = ref_clamp(r[k*BUSW +: BUSW]);
        return r;
    endfunction

    function automatic logic [ROWW-1:0] make_row(input logic [3:0] a, input logic [3:0] b);
        logic [ROWW-1:0] r;
        for (int i = 0; i < N; i++) r[i*4 +: 4] = (i % 2 == 1) ? b : a;
        return r;
    endfunction

    function automatic logic [ROWW-1:0] rand_row();
        logic [ROWW-1:0] r;
        for (int i = 0; i < ROWW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        rowq.delete();
        pbeats  = 0;
        hs_cnt  = 0;
        m_clamp = 0;
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready_o, rowq.size() < 2);
        chk("out_valid", out_valid_o, rowq.size() != 0);
        if (rowq.size() != 0) begin
            chk_row("row_2c", row_2c_o, rowq[0]);
            chk("row_idx", row_idx_o, hs_cnt % NUM_ROWS);
            chk("last_row", last_row_o, (hs_cnt % NUM_ROWS) == NUM_ROWS - 1);
        end
`ifdef LAGD_WLOAD_CLAMP_EN
        chk("clamp_cnt", clamp_cnt_o, m_clamp);
`endif
    endtask

    // Called at a falling edge: check, drive the next cycle's inputs, advance the model.
    task automatic step(input logic v, input logic [BUSW-1:0] d, input logic r, input logic f);
        bit hs, acc, done;
        check_outputs();
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
        if (f) begin
            model_reset();
        end else begin
            hs   = (rowq.size() != 0) && r;
            acc  = v && (rowq.size() < 2);
            done = 0;
            if (hs) hs_log.push_back(int'(row_idx_o) * 2 + int'(last_row_o));
            if (acc) begin
                partial[pbeats*BUSW +: BUSW] = ref_clamp(d);
                m_clamp = m_clamp + count_neg(d);
                if (m_clamp > 16'hFFFF) m_clamp = 16'hFFFF;
                pbeats++;
                if (pbeats == BPR) begin
                    pbeats = 0;
                    done   = 1;
                end
            end
            if (hs) begin
                void'(rowq.pop_front());
                hs_cnt++;
            end
            if (done) rowq.push_back(partial);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b0;
    endtask

    task automatic send_row(input logic [ROWW-1:0] row, input logic rdy);
        int k = 0;
        int guard = 0;
        bit acc;
        while (k < BPR && guard < 200) begin
            acc = rowq.size() < 2;
            step(1'b1, row[k*BUSW +: BUSW], rdy, 1'b0);
            if (acc) k++;
            guard++;
        end
        chk("send_row_beats", k, BPR);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        logic [ROWW-1:0] row_a, row_b, row_c;

        tbl[0] = '{a: 4'h0, b: 4'h7, probe: 0,   exp_val: 4'h0,    exp_idx: 2'd0};
        tbl[1] = '{a: 4'h5, b: 4'hF, probe: 1,   exp_val: 4'hF,    exp_idx: 2'd1};
        tbl[2] = '{a: 4'h8, b: 4'h1, probe: 254, exp_val: NEG_OUT, exp_idx: 2'd2};
        tbl[3] = '{a: 4'h7, b: 4'h8, probe: 255, exp_val: NEG_OUT, exp_idx: 2'd3};
        tbl[4] = '{a: 4'h3, b: 4'hC, probe: 128, exp_val: 4'h3,    exp_idx: 2'd0};

        repeat (3) @(negedge clk_i);
        chk("rst_in_ready", in_ready_o, 1);
        rst_ni = 1'b1;
        chk("rst_out_valid", out_valid_o, 0);
        chk_row("rst_row", row_2c_o, '0);
        chk("rst_row_idx", row_idx_o, 0);
        chk("rst_last_row", last_row_o, 0);
        chk("rst_in_ready2", in_ready_o, 1);

        // Single row, element i = i mod 8.
        for (int i = 0; i < N; i++) row_a[i*4 +: 4] = 4'(i % 8);
        send_row(row_a, 1'b1);
        chk("single_valid", out_valid_o, 1);
        chk_row("single_row", row_2c_o, row_a);
        chk("single_idx", row_idx_o, 0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Table of patterned rows, back to back.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int t = 0; t < 5; t++) begin
            send_row(make_row(tbl[t].a, tbl[t].b), 1'b1);
            chk("tbl_valid", out_valid_o, 1);
            chk("tbl_elem", row_2c_o[tbl[t].probe], tbl[t].exp_val);
            chk("tbl_idx", row_idx_o, tbl[t].exp_idx);
        end
        step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: row 0 held, row 1 fills, loader stalls.
        step(1'b0, '0, 1'b0, 1'b1);
        row_a = rand_row();
        row_b = rand_row();
        row_c = rand_row();
        send_row(row_a, 1'b0);
        send_row(row_b, 1'b0);
        chk("bp_in_ready_low", in_ready_o, 0);
        repeat (3) step(1'b1, row_c[0 +: BUSW], 1'b0, 1'b0);
        chk("bp_idx0", row_idx_o, 0);
        chk_row("bp_row0_stable", row_2c_o, clamp_row(row_a));
        step(1'b1, row_c[0 +: BUSW], 1'b1, 1'b0);
        chk("bp_in_ready_rise", in_ready_o, 1);
        chk("bp_idx1", row_idx_o, 1);
        chk_row("bp_row1", row_2c_o, clamp_row(row_b));
        send_row(row_c, 1'b1);
        chk("bp_idx2", row_idx_o, 2);
        chk_row("bp_row2", row_2c_o, clamp_row(row_c));
        step(1'b0, '0, 1'b1, 1'b0);

        // Row index wrap over 5 rows.
        step(1'b0, '0, 1'b0, 1'b1);
        hs_log.delete();
        for (int r = 0; r < 5; r++) send_row(rand_row(), 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("wrap_count", hs_log.size(), 5);
        for (int r = 0; r < 5 && r < hs_log.size(); r++)
            chk("wrap_idx_last", hs_log[r], (r % 4) * 2 + ((r % 4) == 3 ? 1 : 0));

        // Flush after 7 beats, then a fresh row.
        row_a = rand_row();
        row_b = rand_row();
        for (int k = 0; k < 7; k++) step(1'b1, row_a[k*BUSW +: BUSW], 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("flush_valid_low", out_valid_o, 0);
        send_row(row_b, 1'b1);
        chk_row("flush_new_row", row_2c_o, clamp_row(row_b));
        chk("flush_idx", row_idx_o, 0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-row with a row held at the output.
        row_a = rand_row();
        send_row(row_a, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, row_b[k*BUSW +: BUSW], 1'b0, 1'b0);
        in_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid_o, 0);
        chk("midrst_in_ready", in_ready_o, 1);
        chk("midrst_idx", row_idx_o, 0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        row_c = rand_row();
        send_row(row_c, 1'b1);
        chk_row("midrst_next_row", row_2c_o, clamp_row(row_c));
        step(1'b0, '0, 1'b1, 1'b0);

        // Most-negative codes at four positions.
        step(1'b0, '0, 1'b0, 1'b1);
        row_a = make_row(4'h1, 4'h1);
        row_a[0*4 +: 4]   = 4'h8;
        row_a[3*4 +: 4]   = 4'h8;
        row_a[100*4 +: 4] = 4'h8;
        row_a[255*4 +: 4] = 4'h8;
        send_row(row_a, 1'b1);
        chk("neg_e0", row_2c_o[0], NEG_OUT);
        chk("neg_e3", row_2c_o[3], NEG_OUT);
        chk("neg_e100", row_2c_o[100], NEG_OUT);
        chk("neg_e255", row_2c_o[255], NEG_OUT);
        chk("neg_e1", row_2c_o[1], 4'h1);
`ifdef LAGD_WLOAD_CLAMP_EN
        chk("neg_clamp_cnt", clamp_cnt_o, 4);
`endif
        step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic against the model.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int c = 0; c < 1500; c++)
            step($urandom_range(0, 3) != 0, {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
